// File: rtl/cp0_reg.sv
// MIPS coprocessor-0 register file: Count/Compare timer, Status, Cause, EPC, PRId, Config.
// Reads are combinational from registered state; writes land on the rising edge.
module cp0_reg #(
    parameter logic [31:0] PRID_VALUE = 32'h00480102,
    parameter int unsigned COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    output logic [31:0] data_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] config_o,
    output logic [31:0] prid_o,
    output logic        timer_int_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned PRE_W  = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    localparam logic [ADDR_W-1:0] REG_COUNT   = ADDR_W'(9);
    localparam logic [ADDR_W-1:0] REG_COMPARE = ADDR_W'(11);
    localparam logic [ADDR_W-1:0] REG_STATUS  = ADDR_W'(12);
    localparam logic [ADDR_W-1:0] REG_CAUSE   = ADDR_W'(13);
    localparam logic [ADDR_W-1:0] REG_EPC     = ADDR_W'(14);
    localparam logic [ADDR_W-1:0] REG_PRID    = ADDR_W'(15);
    localparam logic [ADDR_W-1:0] REG_CONFIG  = ADDR_W'(16);

    localparam logic [DATA_W-1:0] STATUS_RST  = 32'h1000_0000;
    localparam logic [DATA_W-1:0] CONFIG_RST  = 32'h0000_8000;
    // Software-writable Cause bits: IV, WP, IP1:0
    localparam logic [DATA_W-1:0] CAUSE_WMASK = 32'h00C0_0300;

    localparam logic [PRE_W-1:0]  PRE_LAST    = PRE_W'(COUNT_DIV - 1);

    logic [DATA_W-1:0] count_q;
    logic [DATA_W-1:0] compare_q;
    logic [DATA_W-1:0] status_q;
    logic [DATA_W-1:0] cause_q;
    logic [DATA_W-1:0] cause_next;
    logic [DATA_W-1:0] epc_q;
    logic [PRE_W-1:0]  pre_q;
    logic              timer_q;

    logic wr_count;
    logic wr_compare;
    logic wr_status;
    logic wr_cause;
    logic wr_epc;
    logic pre_wrap;
    logic timer_hit;

    assign wr_count   = we_i && (waddr_i == REG_COUNT);
    assign wr_compare = we_i && (waddr_i == REG_COMPARE);
    assign wr_status  = we_i && (waddr_i == REG_STATUS);
    assign wr_cause   = we_i && (waddr_i == REG_CAUSE);
    assign wr_epc     = we_i && (waddr_i == REG_EPC);
    assign pre_wrap   = (pre_q == PRE_LAST);
    assign timer_hit  = (count_q == compare_q) && (compare_q != '0);

    // Prescaled free-running Count; a software write reloads it and restarts the prescale
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            pre_q   <= '0;
        end else if (wr_count) begin
            count_q <= data_i;
            pre_q   <= '0;
        end else if (pre_wrap) begin
            count_q <= count_q + DATA_W'(1);
            pre_q   <= '0;
        end else begin
            pre_q   <= pre_q + PRE_W'(1);
        end
    end

    // Sticky timer interrupt; a Compare write acknowledges it and beats a same-edge match
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            compare_q <= '0;
            timer_q   <= 1'b0;
        end else if (wr_compare) begin
            compare_q <= data_i;
            timer_q   <= 1'b0;
        end else if (timer_hit) begin
            timer_q   <= 1'b1;
        end
    end

    always_comb begin
        cause_next = cause_q;
        if (wr_cause) begin
            cause_next = (cause_q & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);
        end
        cause_next[15:10] = int_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_q <= STATUS_RST;
            cause_q  <= '0;
            epc_q    <= '0;
        end else begin
            cause_q <= cause_next;
            if (wr_status) begin
                status_q <= data_i;
            end
            if (wr_epc) begin
                epc_q <= data_i;
            end
        end
    end

    always_comb begin
        data_o = '0;
        case (raddr_i)
            REG_COUNT:   data_o = count_q;
            REG_COMPARE: data_o = compare_q;
            REG_STATUS:  data_o = status_q;
            REG_CAUSE:   data_o = cause_q;
            REG_EPC:     data_o = epc_q;
            REG_PRID:    data_o = PRID_VALUE;
            REG_CONFIG:  data_o = CONFIG_RST;
            default:     data_o = '0;
        endcase
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign status_o    = status_q;
    assign cause_o     = cause_q;
    assign epc_o       = epc_q;
    assign config_o    = CONFIG_RST;
    assign prid_o      = PRID_VALUE;
    assign timer_int_o = timer_q;

endmodule

// File: tb/tb_cp0_reg.sv
// Directed bench for cp0_reg with the default COUNT_DIV of 2 and hand-computed expectations.
module tb_cp0_reg;

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] data_i;
    logic [4:0]  raddr_i;
    logic [5:0]  int_i;
    logic [31:0] data_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] config_o;
    logic [31:0] prid_o;
    logic        timer_int_o;

    int n_tests = 0;
    int n_fail  = 0;

    cp0_reg dut (
        .clk         (clk),
        .rst         (rst),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .data_i      (data_i),
        .raddr_i     (raddr_i),
        .int_i       (int_i),
        .data_o      (data_o),
        .count_o     (count_o),
        .compare_o   (compare_o),
        .status_o    (status_o),
        .cause_o     (cause_o),
        .epc_o       (epc_o),
        .config_o    (config_o),
        .prid_o      (prid_o),
        .timer_int_o (timer_int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we_i    = 1'b1;
        waddr_i = a;
        data_i  = d;
        tick();
        we_i    = 1'b0;
    endtask

    initial begin
        rst     = 1'b0;
        we_i    = 1'b0;
        waddr_i = '0;
        data_i  = '0;
        raddr_i = 5'd15;
        int_i   = '0;
        #12;
        check("rst_count",   count_o, 32'h0);
        check("rst_status",  status_o, 32'h1000_0000);
        check("rst_config",  config_o, 32'h0000_8000);
        check("rst_prid",    prid_o, 32'h0048_0102);
        check("rst_timer",   32'(timer_int_o), 32'h0);
        check("rst_rd_prid", data_o, 32'h0048_0102);

        // Ten edges after release with COUNT_DIV=2 yield Count=5
        rst = 1'b1;
        repeat (10) tick();
        check("idle_count",  count_o, 32'd5);
        check("idle_status", status_o, 32'h1000_0000);
        check("idle_config", config_o, 32'h0000_8000);

        // Compare=3, Count=0: Count reaches 3 six edges later, interrupt one edge after that
        wr(5'd11, 32'd3);
        wr(5'd9, 32'd0);
        repeat (6) tick();
        check("cmp3_count",   count_o, 32'd3);
        check("cmp3_timer_0", 32'(timer_int_o), 32'h0);
        tick();
        check("cmp3_timer_1", 32'(timer_int_o), 32'h1);
        tick();
        check("cmp3_count4",  count_o, 32'd4);
        check("cmp3_sticky",  32'(timer_int_o), 32'h1);
        wr(5'd11, 32'd8);
        check("cmp8_clear",   32'(timer_int_o), 32'h0);
        check("cmp8_value",   compare_o, 32'd8);

        // Compare write beats a same-edge match; the following edge still matches
        wr(5'd9, 32'd8);
        wr(5'd11, 32'd8);
        check("cmp_prio_timer", 32'(timer_int_o), 32'h0);
        tick();
        check("cmp_prio_hit",   32'(timer_int_o), 32'h1);
        check("cmp_prio_count", count_o, 32'd9);

        // Count wrap with Compare=0 never raises the interrupt
        wr(5'd11, 32'd0);
        check("cmp0_clear", 32'(timer_int_o), 32'h0);
        wr(5'd9, 32'hFFFF_FFFF);
        check("wrap_load", count_o, 32'hFFFF_FFFF);
        tick();
        check("wrap_hold", count_o, 32'hFFFF_FFFF);
        tick();
        check("wrap_zero", count_o, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("cmp0_no_timer", 32'(timer_int_o), 32'h0);
        end

        // Cause: only IV/WP/IP1:0 writable, IP7:2 mirror int_i
        int_i   = 6'b101010;
        raddr_i = 5'd13;
        wr(5'd13, 32'hFFFF_FFFF);
        check("cause_wr",    cause_o, 32'h00C0_AB00);
        check("cause_rd",    data_o, 32'h00C0_AB00);
        int_i = 6'b000000;
        tick();
        check("cause_int0",  cause_o, 32'h00C0_0300);

        // EPC read-after-write has one cycle latency
        we_i    = 1'b1;
        waddr_i = 5'd14;
        data_i  = 32'hBFC0_0100;
        raddr_i = 5'd14;
        #1;
        check("epc_old", data_o, 32'h0);
        tick();
        we_i = 1'b0;
        check("epc_new", data_o, 32'hBFC0_0100);
        check("epc_out", epc_o, 32'hBFC0_0100);
        raddr_i = 5'd5;
        #1;
        check("rd_unimpl", data_o, 32'h0);

        // Status fully writable; PRId/Config read-only; we_i=0 ignores the bus
        wr(5'd12, 32'h1234_5678);
        check("status_wr", status_o, 32'h1234_5678);
        raddr_i = 5'd15;
        wr(5'd15, 32'hFFFF_FFFF);
        check("prid_ro",   data_o, 32'h0048_0102);
        raddr_i = 5'd16;
        wr(5'd16, 32'h0);
        check("config_ro", data_o, 32'h0000_8000);
        waddr_i = 5'd12;
        data_i  = 32'h0;
        tick();
        check("we_off",    status_o, 32'h1234_5678);

        // Asynchronous reset mid-operation with interrupt pending and Count=100
        wr(5'd11, 32'd5);
        wr(5'd9, 32'd5);
        wr(5'd9, 32'd100);
        check("pre_rst_timer", 32'(timer_int_o), 32'h1);
        check("pre_rst_count", count_o, 32'd100);
        #2;
        rst = 1'b0;
        #1;
        check("arst_count",   count_o, 32'h0);
        check("arst_compare", compare_o, 32'h0);
        check("arst_timer",   32'(timer_int_o), 32'h0);
        check("arst_status",  status_o, 32'h1000_0000);
        check("arst_cause",   cause_o, 32'h0);
        check("arst_epc",     epc_o, 32'h0);
        check("arst_config",  config_o, 32'h0000_8000);

        // Counting restarts from a clean prescale after release
        rst = 1'b1;
        repeat (3) tick();
        check("rerun_count", count_o, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_reg.md
CP0_REG -- requirements
Module: cp0_reg

Interface
REQ-001 SHALL have parameter PRID_VALUE, default 32'h00480102, read-only PRId (reg 15) value.
REQ-002 SHALL have parameter COUNT_DIV, default 2, clock cycles per Count increment; legal range 1..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port we_i  input  1  CP0 write enable from MEM stage.
REQ-006 SHALL have port waddr_i  input  5  CP0 register number to write.
REQ-007 SHALL have port data_i  input  32  CP0 write data.
REQ-008 SHALL have port raddr_i  input  5  CP0 register number to read (EX stage mfc0).
REQ-009 SHALL have port int_i  input  6  external hardware interrupt lines.
REQ-010 SHALL have port data_o  output  32  read data for raddr_i.
REQ-011 SHALL have ports count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  output  32 each  current register values.
REQ-012 SHALL have port timer_int_o  output  1  timer interrupt pending.

Function
REQ-013 SHALL implement Count(9), Compare(11), Status(12), Cause(13), EPC(14), PRId(15), Config(16); all other numbers unimplemented.
REQ-014 SHALL drive data_o combinationally from registered state: raddr_i selects register, unimplemented numbers return 32'h0; no bypass of same-cycle writes (one-cycle read-after-write latency).
REQ-015 SHALL keep a prescaler counter 0..COUNT_DIV-1; Count increments by 1 on the edge where the prescaler equals COUNT_DIV-1, prescaler then wraps to 0.
REQ-016 SHALL wrap Count from 32'hFFFFFFFF to 32'h0 with no flag.
REQ-017 SHALL, on write to Count, load data_i and reset prescaler to 0; write wins over a same-cycle increment.
REQ-018 SHALL, on write to Compare, load data_i and clear timer_int_o in the same edge.
REQ-019 SHALL set timer_int_o on the edge after Count == Compare while Compare != 0; sticky until Compare write or reset.
REQ-020 SHALL give Compare write priority over a same-cycle match (timer_int_o ends 0).
REQ-021 SHALL write all 32 bits of Status and EPC from data_i.
REQ-022 SHALL, on write to Cause, update only bits 9:8 (IP1:0), 22 (WP), 23 (IV); other bits unaffected.
REQ-023 SHALL load Cause[15:10] from int_i on every edge (one-cycle sampling latency) regardless of writes.
REQ-024 SHALL ignore writes to PRId, Config and unimplemented numbers.
REQ-025 SHALL ignore waddr_i and data_i when we_i is 0.

Reset
REQ-026 SHALL, while rst is 0, force Count, Compare, EPC, Cause, prescaler to 0 and timer_int_o to 0, asynchronously.
REQ-027 SHALL reset Status to 32'h10000000 (CU0=1).
REQ-028 SHALL reset Config to 32'h00008000 (BE=1); prid_o equals PRID_VALUE at all times.
REQ-029 SHALL resume counting on the first rising edge after rst returns to 1, prescaler starting at 0; reset mid-count discards the partial prescale.

Verification
REQ-030 SHALL cover: release reset, idle 10 cycles, COUNT_DIV=2 -> count_o = 5, status_o = 32'h10000000, config_o = 32'h00008000.
REQ-031 SHALL cover: write Compare=3, Count=0 -> timer_int_o rises one cycle after count_o = 3; write Compare=8 -> timer_int_o 0 next cycle.
REQ-032 SHALL cover: write Count=32'hFFFFFFFF -> after COUNT_DIV cycles count_o = 0; Compare=0 never raises timer_int_o.
REQ-033 SHALL cover: write Cause with 32'hFFFFFFFF, int_i=6'b101010 -> cause_o = 32'h00C0AB00 next cycle.
REQ-034 SHALL cover: write EPC=32'hBFC00100 and read raddr_i=14 same cycle -> data_o old value; next cycle 32'hBFC00100; raddr_i=5 -> 0.
REQ-035 SHALL cover: assert rst mid-operation with timer_int_o=1, Count=100 -> all outputs at reset values immediately, before next clock edge.
